// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator for a 32-bit word-addressed data memory.
//
// The memory has a combinational read, a synchronous write and a single
// full-word write enable. Byte/halfword stores therefore go through a
// read-modify-write sequence (READ then WRITE). Loads are sign- or
// zero-extended from the selected lane.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE, and req_* inputs
// are ignored in every other state. rsp_valid is a one-cycle pulse with
// rsp_rdata / rsp_error valid in the same cycle; there is no back-pressure
// on the response.
//
// Optional build macro: LSU_BOUNDS_CHECK_EN. When defined, a request with
// req_addr >= MEM_BYTES is answered with an error and no memory access.
// When undefined, the address passes through and the memory aliases.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/ready/we/funct3  request handshake and decode (RV32I funct3)
//   req_addr, req_wdata        byte address, store data (low bytes for SB/SH)
//   rsp_valid/rdata/error      one-cycle response
//   mem_address/wdata/we       word access to memory ({addr[31:2],2'b00})
//   mem_rdata                  combinational memory read data
//   dbg_state                  current FSM state (IDLE=0 READ=1 WRITE=2 RESP=3)

module lsu_mem_master #(
  parameter int unsigned MEM_BYTES = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_n;

  logic [31:0] addr_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [15:0] wdata_q;    // only the SB/SH lanes are ever needed after accept
  logic [31:0] wbuf_q;
  logic [31:0] rdata_q;
  logic        error_q;

  // ---------------- request decode (used in IDLE only) ----------------
  logic misaligned, illegal_f3, addr_oor, bounds_err, req_err;

  always_comb begin
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign illegal_f3 = req_we ? (req_funct3 >= 3'd3)
                             : (req_funct3 == 3'd3 || req_funct3 == 3'd6 ||
                                req_funct3 == 3'd7);

  assign addr_oor = (req_addr >= 32'(MEM_BYTES));

`ifdef LSU_BOUNDS_CHECK_EN
  assign bounds_err = addr_oor;
`else
  // Range is still computed so both builds share one decode; this build
  // ignores it and lets the memory alias.
  assign bounds_err = 1'b0 && addr_oor;
`endif

  assign req_err = misaligned || illegal_f3 || bounds_err;

  // ---------------- READ-cycle datapath ----------------
  logic [31:0] shifted, load_data, merged;

  assign shifted = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_data = shifted;
    case (f3_q)
      3'd0:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    load_data = {24'd0, shifted[7:0]};
      3'd5:    load_data = {16'd0, shifted[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  // Merge store lanes into the word just read; other bytes are preserved.
  always_comb begin
    merged = mem_rdata;
    if (f3_q[1:0] == 2'd0)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                          state_n = RESP;
          else if (req_we && req_funct3 == 3'd2) state_n = WRITE;
          else                                  state_n = READ;
        end
      end
      READ:    state_n = we_q ? WRITE : RESP;
      WRITE:   state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_ready   = (state == IDLE);
    rsp_valid   = (state == RESP);
    // Reset during WRITE suppresses the write combinationally.
    mem_we      = (state == WRITE) && !reset;
    mem_address = (state == IDLE) ? 32'd0 : {addr_q[31:2], 2'b00};
  end

  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;
  assign mem_wdata = wbuf_q;
  assign dbg_state = state;

  // ---------------- registered datapath ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      wdata_q <= 16'd0;
      wbuf_q  <= 32'd0;
      rdata_q <= 32'd0;
      error_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            f3_q    <= req_funct3;
            wdata_q <= req_wdata[15:0];
            rdata_q <= 32'd0;
            error_q <= req_err;
            if (!req_err && req_we && req_funct3 == 3'd2) wbuf_q <= req_wdata;
          end
        end
        READ: begin
          if (we_q) wbuf_q  <= merged;
          else      rdata_q <= load_data;
        end
        RESP: begin
          rdata_q <= 32'd0;
          error_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Testbench for lsu_mem_master: table of directed requests with expected
// response data, error flag, latency, write-enable cycle and resulting memory
// word, plus hand-written reset-state and reset-during-WRITE sequences.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lsu_mem_master #(.MEM_BYTES(16384)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .dbg_state(dbg_state)
  );

  // Memory model: 4096 words, combinational read, synchronous write,
  // aliasing on the low index bits.
  logic [31:0] mem [0:4095];
  assign mem_rdata = mem[mem_address[13:2]];
  always @(posedge clk) if (mem_we) mem[mem_address[13:2]] <= mem_wdata;

  function automatic logic [31:0] peek(input logic [31:0] a);
    return mem[a[13:2]];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_we_cyc;   // 0 = mem_we never high
    logic [31:0] chk_addr;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err,
                     input int exp_lat, input int exp_we_cyc,
                     input logic [31:0] chk_addr, input logic [31:0] exp_word);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_we_cyc = exp_we_cyc; v.chk_addr = chk_addr; v.exp_word = exp_word;
    vecs.push_back(v);
  endtask

  // Drive one request at a negedge, let it be accepted at the next posedge,
  // then observe five cycles (sampled on negedges) after the accept edge.
  task automatic run_vec(input vec_t v);
    int t, lat, we_cyc, we_cnt;
    logic [31:0] rd;
    logic er, rdy_at_rsp;
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    chk({v.name, " ready_before"}, {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_addr   = 32'hFFFF_FFFC;   // garbage that must be ignored
    req_wdata  = 32'h5A5A_5A5A;
    lat = 0; we_cyc = 0; we_cnt = 0; rd = 32'hX; er = 1'bX; rdy_at_rsp = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (mem_we) begin we_cnt++; we_cyc = k; end
      if (k == 1 && !v.exp_err)
        chk({v.name, " mem_address"}, mem_address, {v.addr[31:2], 2'b00});
      if (rsp_valid && lat == 0) begin
        lat = k; rd = rsp_rdata; er = rsp_error; rdy_at_rsp = req_ready;
      end
    end
    chk({v.name, " latency"}, lat, v.exp_lat);
    chk({v.name, " rsp_rdata"}, rd, v.exp_rdata);
    chk({v.name, " rsp_error"}, {31'd0, er}, {31'd0, v.exp_err});
    chk({v.name, " ready_in_resp"}, {31'd0, rdy_at_rsp}, 32'd0);
    chk({v.name, " we_cycle"}, we_cyc, v.exp_we_cyc);
    chk({v.name, " we_count"}, we_cnt, (v.exp_we_cyc != 0) ? 1 : 0);
    chk({v.name, " mem_word"}, peek(v.chk_addr), v.exp_word);
  endtask

`ifdef LSU_BOUNDS_CHECK_EN
  localparam logic        OOR_ERR  = 1'b1;
  localparam int          OOR_LAT  = 1;
  localparam int          OOR_WE   = 0;
  localparam logic [31:0] OOR_WORD = 32'h1111_1111;
`else
  localparam logic        OOR_ERR  = 1'b0;
  localparam int          OOR_LAT  = 2;
  localparam int          OOR_WE   = 1;
  localparam logic [31:0] OOR_WORD = 32'h0BAD_F00D;
`endif

  initial begin
    int t;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    mem[12'h080] = 32'h8899_AABB;   // byte 0x200
    mem[12'h0C0] = 32'hAABB_CCDD;   // byte 0x300
    mem[12'h000] = 32'h1111_1111;   // byte 0x000 (alias target of 0x4000)

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset rsp_error", {31'd0, rsp_error}, 32'd0);
    chk("reset mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset mem_address", mem_address, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // ---- directed table ----
    //   name         we  f3  addr       wdata         rdata         err lat wec chk_addr   word
    add("LB_201",    0, 0, 32'h201, 32'h0,         32'hFFFFFFAA, 0, 2, 0, 32'h200, 32'h8899AABB);
    add("LBU_201",   0, 4, 32'h201, 32'h0,         32'h000000AA, 0, 2, 0, 32'h200, 32'h8899AABB);
    add("LH_202",    0, 1, 32'h202, 32'h0,         32'hFFFF8899, 0, 2, 0, 32'h200, 32'h8899AABB);
    add("LHU_202",   0, 5, 32'h202, 32'h0,         32'h00008899, 0, 2, 0, 32'h200, 32'h8899AABB);
    add("LW_200",    0, 2, 32'h200, 32'h0,         32'h8899AABB, 0, 2, 0, 32'h200, 32'h8899AABB);
    add("SH_200",    1, 1, 32'h200, 32'hCAFE1234,  32'h0,        0, 3, 2, 32'h200, 32'h88991234);
    add("SB_203",    1, 0, 32'h203, 32'h12345677,  32'h0,        0, 3, 2, 32'h200, 32'h77991234);
    add("SW_204",    1, 2, 32'h204, 32'hDEADBEEF,  32'h0,        0, 2, 1, 32'h204, 32'hDEADBEEF);
    add("LW_200b",   0, 2, 32'h200, 32'h0,         32'h77991234, 0, 2, 0, 32'h200, 32'h77991234);
    add("LH_200",    0, 1, 32'h200, 32'h0,         32'h00001234, 0, 2, 0, 32'h200, 32'h77991234);
    add("LB_203",    0, 0, 32'h203, 32'h0,         32'h00000077, 0, 2, 0, 32'h200, 32'h77991234);
    add("LB_204",    0, 0, 32'h204, 32'h0,         32'hFFFFFFEF, 0, 2, 0, 32'h204, 32'hDEADBEEF);
    add("SB_205",    1, 0, 32'h205, 32'h000000A5,  32'h0,        0, 3, 2, 32'h204, 32'hDEADA5EF);
    add("E_LW_202",  0, 2, 32'h202, 32'h0,         32'h0,        1, 1, 0, 32'h200, 32'h77991234);
    add("E_SH_201",  1, 1, 32'h201, 32'hFFFFFFFF,  32'h0,        1, 1, 0, 32'h200, 32'h77991234);
    add("E_LD_F3",   0, 3, 32'h200, 32'h0,         32'h0,        1, 1, 0, 32'h200, 32'h77991234);
    add("E_ST_F4",   1, 4, 32'h200, 32'hFFFFFFFF,  32'h0,        1, 1, 0, 32'h200, 32'h77991234);
    add("E_LHU_203", 0, 5, 32'h203, 32'h0,         32'h0,        1, 1, 0, 32'h200, 32'h77991234);
    add("SW_4000",   1, 2, 32'h4000, 32'h0BADF00D, 32'h0,  OOR_ERR, OOR_LAT, OOR_WE, 32'h0, OOR_WORD);

    foreach (vecs[i]) run_vec(vecs[i]);

    // ---- reset during the WRITE cycle of an SB ----
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0;
    req_addr = 32'h300; req_wdata = 32'h0000_0055;
    @(posedge clk);            // accept -> READ
    #1 req_valid = 1'b0;
    @(posedge clk);            // -> WRITE
    @(negedge clk);
    chk("rst_wr state_is_write", {30'd0, dbg_state}, 32'd2);
    reset = 1'b1;
    #1;
    chk("rst_wr mem_we_suppressed", {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_wr ready_after", {31'd0, req_ready}, 32'd1);
    chk("rst_wr word_unchanged", peek(32'h300), 32'hAABBCCDD);
    t = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid || mem_we) t++;
    end
    chk("rst_wr no_rsp_no_we", t, 0);
    chk("rst_wr word_final", peek(32'h300), 32'hAABBCCDD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
